sobel_edge_stage: RTL and testbench

- Streaming 3x3 Sobel gradient stage placed directly downstream of the Gaussian blur stage.
- Consumes blurred 8-bit pixels in raster order and buffers two image lines internally.
- Applies the shared sobel_x/sobel_y kernels and emits one 8-bit edge magnitude per input pixel toward the UART transmit path.
- No backpressure: the UART-paced source rate is far below the clock rate.

---
 rtl/definitions_pkg.sv | 44 ++++
 rtl/sobel_edge_stage_if.sv | 22 ++
 rtl/line_buffer.sv | 26 ++
 rtl/sobel_edge_stage.sv | 133 +++++++++++++
 tb/tb_sobel_edge_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared image geometry, pixel/gradient types and Sobel kernels
package definitions_pkg;

    localparam int IMAGE_WIDTH  = 512;
    localparam int IMAGE_HEIGHT = 512;

    typedef logic [7:0]         pixel_t;
    typedef logic signed [10:0] grad_t;
    typedef logic signed [2:0]  coeff_t;

    // Row-major, top-left first.
    localparam coeff_t sobel_x [9] = '{
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd2, 3'sd0, 3'sd2,
        -3'sd1, 3'sd0, 3'sd1
    };
    localparam coeff_t sobel_y [9] = '{
        -3'sd1, -3'sd2, -3'sd1,
         3'sd0,  3'sd0,  3'sd0,
         3'sd1,  3'sd2,  3'sd1
    };

    // Sum of window pixel times kernel coefficient; |result| <= 1020 so 11 bits suffice.
    function automatic grad_t convolve(input pixel_t win [9], input coeff_t kern [9]);
        grad_t acc;
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + grad_t'({3'b000, win[i]}) * grad_t'(kern[i]);
        end
        return acc;
    endfunction

    // |gx| + |gy| clipped to the 8-bit output range.
    function automatic pixel_t sat_magnitude(input grad_t gx, input grad_t gy);
        logic [10:0] ax;
        logic [10:0] ay;
        logic [11:0] sum;
        ax  = gx[10] ? 11'(-gx) : 11'(gx);
        ay  = gy[10] ? 11'(-gy) : 11'(gy);
        sum = {1'b0, ax} + {1'b0, ay};
        return (sum > 12'd255) ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/sobel_edge_stage_if.sv
// rtl/sobel_edge_stage_if.sv - pixel stream in/out bundle of the Sobel stage
interface sobel_edge_stage_if;
    import definitions_pkg::*;

    logic   in_valid;
    pixel_t in_pixel;
    logic   out_valid;
    pixel_t out_pixel;
    logic   out_eof;

    // Upstream/downstream environment side: drives pixels in, observes edge magnitudes.
    modport master (
        output in_valid, in_pixel,
        input  out_valid, out_pixel, out_eof
    );

    // Sobel stage side.
    modport slave (
        input  in_valid, in_pixel,
        output out_valid, out_pixel, out_eof
    );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port line RAM, synchronous write, read returns pre-write data
module line_buffer
    import definitions_pkg::*;
#(
    parameter int DEPTH = IMAGE_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  pixel_t                   wdata,
    output pixel_t                   rdata
);

    pixel_t mem_q [DEPTH];

    // Combinational read of the addressed entry, so the same-cycle read sees the old value.
    assign rdata = mem_q[addr];

    // Write lands at the clock edge, after the read has been consumed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_edge_stage.sv
// rtl/sobel_edge_stage.sv - streaming 3x3 Sobel edge magnitude with two line buffers
module sobel_edge_stage
    import definitions_pkg::*;
#(
    parameter int IMAGE_WIDTH  = definitions_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = definitions_pkg::IMAGE_HEIGHT
) (
    input  logic                clk,
    input  logic                reset,
    sobel_edge_stage_if.slave   px
);

    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    pixel_t           win_q [9];
    pixel_t           win_d [9];

    logic   s1_valid_q, s1_valid_d;
    logic   s1_border_q, s1_border_d;
    logic   s1_eof_q, s1_eof_d;
    grad_t  gx_q, gx_d;
    grad_t  gy_q, gy_d;

    logic   out_valid_q, out_valid_d;
    pixel_t out_pixel_q, out_pixel_d;
    logic   out_eof_q, out_eof_d;

    pixel_t lb0_rdata;
    pixel_t lb1_rdata;
    logic   lb_we;

    // A pixel arriving together with reset is dropped, so the RAMs are not touched either.
    assign lb_we = px.in_valid & ~reset;

    // lb0: previous line, refilled with the incoming pixel.
    line_buffer #(.DEPTH(IMAGE_WIDTH)) u_lb0 (
        .clk   (clk),
        .we    (lb_we),
        .addr  (col_q),
        .wdata (px.in_pixel),
        .rdata (lb0_rdata)
    );

    // lb1: line before that, refilled with what lb0 held at this column.
    line_buffer #(.DEPTH(IMAGE_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (lb_we),
        .addr  (col_q),
        .wdata (lb0_rdata),
        .rdata (lb1_rdata)
    );

    // Raster counters, window shift and stage-1 gradients for each accepted pixel.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        s1_valid_d  = px.in_valid;
        s1_border_d = s1_border_q;
        s1_eof_d    = 1'b0;
        gx_d        = gx_q;
        gy_d        = gy_q;
        if (px.in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb1_rdata;
            win_d[5] = lb0_rdata;
            win_d[8] = px.in_pixel;
            gx_d = convolve(win_d, sobel_x);
            gy_d = convolve(win_d, sobel_y);
            // Window centre is (row-1, col-1); it crosses the frame edge for the first two rows/cols.
            s1_border_d = (row_q < ROW_W'(2)) || (col_q < COL_W'(2));
            s1_eof_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Stage 2: saturated magnitude, zeroed where the window straddles the border.
    always_comb begin
        out_valid_d = s1_valid_q;
        out_eof_d   = s1_valid_q & s1_eof_q;
        out_pixel_d = out_pixel_q;
        if (s1_valid_q) begin
            out_pixel_d = s1_border_q ? 8'd0 : sat_magnitude(gx_q, gy_q);
        end
    end

    // State registers; reset clears counters, window and both pipeline stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_eof_q    <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            s1_valid_q  <= s1_valid_d;
            s1_border_q <= s1_border_d;
            s1_eof_q    <= s1_eof_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign px.out_valid = out_valid_q;
    assign px.out_pixel = out_pixel_q;
    assign px.out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_edge_stage.sv
// tb/tb_sobel_edge_stage.sv - directed self-checking bench for sobel_edge_stage
module tb_sobel_edge_stage;
    import definitions_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    localparam int T_FLAT  = 0;
    localparam int T_VSTEP = 1;
    localparam int T_HSTEP = 2;
    localparam int T_SAT   = 3;

    typedef struct {
        int pix;
        int eof;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   eof_seen = 0;
    int   drv_row;
    int   drv_col;
    exp_t exp_q [$];
    exp_t mon_e;

    sobel_edge_stage_if px ();

    sobel_edge_stage #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .px    (px)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pattern(input int t, input int r, input int c);
        case (t)
            T_FLAT:  return 77;
            T_VSTEP: return (c >= 4) ? 20 : 0;
            T_HSTEP: return (r >= 3) ? 30 : 0;
            default: return (r == 2 && c == 3) ? 255 : 0;
        endcase
    endfunction

    // Hand-derived results for input (r,c), whose window is centred at (r-1,c-1).
    function automatic int expected(input int t, input int r, input int c);
        if (r < 2 || c < 2) return 0;
        case (t)
            T_FLAT:  return 0;
            T_VSTEP: return (c == 4 || c == 5) ? 80 : 0;
            T_HSTEP: return (r == 3 || r == 4) ? 120 : 0;
            default: return (r >= 2 && r <= 4 && c >= 3 && c <= 5 && !(r == 3 && c == 4)) ? 255 : 0;
        endcase
    endfunction

    task automatic send_pixel(input int t, input int gap_max);
        exp_t e;
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        #1;
        px.in_valid = 1'b1;
        px.in_pixel = 8'(pattern(t, drv_row, drv_col));
        e.pix = expected(t, drv_row, drv_col);
        e.eof = (drv_row == H - 1 && drv_col == W - 1) ? 1 : 0;
        e.cyc = cyc;
        exp_q.push_back(e);
        if (drv_col == W - 1) begin
            drv_col = 0;
            drv_row = (drv_row == H - 1) ? 0 : drv_row + 1;
        end else begin
            drv_col++;
        end
        @(posedge clk);
        #1;
        px.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int t, input int gap_max);
        drv_row = 0;
        drv_col = 0;
        for (int i = 0; i < W * H; i++) send_pixel(t, gap_max);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (px.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pixel", int'(px.out_pixel), mon_e.pix);
                check("out_eof", int'(px.out_eof), mon_e.eof);
                check("latency", cyc - mon_e.cyc, 2);
            end
            if (px.out_eof === 1'b1) eof_seen++;
        end else if (px.out_eof !== 1'b0) begin
            check("eof_without_valid", int'(px.out_eof), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        px.in_valid = 1'b0;
        px.in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(px.out_valid), 0);
        check("rst_out_pixel", int'(px.out_pixel), 0);
        check("rst_out_eof", int'(px.out_eof), 0);
        reset = 1'b0;
        @(posedge clk);

        send_frame(T_FLAT, 0);
        drain();
        send_frame(T_VSTEP, 0);
        drain();
        send_frame(T_HSTEP, 0);
        drain();
        send_frame(T_SAT, 0);
        drain();
        send_frame(T_VSTEP, 1);
        drain();

        // Partial flat frame, then reset together with pixel (3,5).
        drv_row = 0;
        drv_col = 0;
        while (!(drv_row == 3 && drv_col == 5)) send_pixel(T_FLAT, 0);
        reset       = 1'b1;
        px.in_valid = 1'b1;
        px.in_pixel = 8'd77;
        while (exp_q.size() > 0 && exp_q[$].cyc + 2 > cyc) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        reset       = 1'b0;
        px.in_valid = 1'b0;
        check("post_rst_valid0", int'(px.out_valid), 0);
        @(posedge clk);
        #1;
        check("post_rst_valid1", int'(px.out_valid), 0);
        drain();
        send_frame(T_FLAT, 0);
        drain();

        check("eof_count", eof_seen, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
